// File: rtl/median_pkg.sv
// Shared types and helpers for the sliding-window median controller.
package median_pkg;

  localparam int MEDIAN_N = 5;

  typedef logic [31:0] data_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic data_t umin(data_t a, data_t b);
    return (a <= b) ? a : b;
  endfunction

  function automatic data_t umax(data_t a, data_t b);
    return (a <= b) ? b : a;
  endfunction

endpackage

// File: rtl/median5_net.sv
// Combinational 5-input median: 7 compare-exchanges in 5 stages.
module median5_net
  import median_pkg::*;
(
  input  data_t d0_i,
  input  data_t d1_i,
  input  data_t d2_i,
  input  data_t d3_i,
  input  data_t d4_i,
  output data_t med_o
);

  data_t a0, a1, a3, a4;
  data_t b1, b3;
  data_t c1, c2, c3;

  // Overall min/max of {d0,d1,d3,d4} are dropped: neither can be the median.
  always_comb begin
    a0    = umin(d0_i, d1_i);
    a1    = umax(d0_i, d1_i);
    a3    = umin(d3_i, d4_i);
    a4    = umax(d3_i, d4_i);
    b3    = umax(a0, a3);
    b1    = umin(a1, a4);
    c1    = umin(b1, d2_i);
    c2    = umax(b1, d2_i);
    c3    = umin(c2, b3);
    med_o = umax(c1, c3);
  end

endmodule

// File: rtl/median_window_ctrl.sv
// Five-sample sliding window with warm-up, flush and a
// registered valid/ready median output.
module median_window_ctrl
  import median_pkg::*;
#(
  parameter bit PAD_MODE = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  in_valid,
  output logic  in_ready,
  input  data_t in_data,
  output logic  out_valid,
  input  logic  out_ready,
  output data_t out_median
);

  data_t      win_q [MEDIAN_N];
  data_t      win_d [MEDIAN_N];
  logic [2:0] fill_q, fill_d;
  state_t     state_q, state_d;
  logic       ov_q, ov_d;
  data_t      med_q, med_d;
  data_t      net_med;
  logic       accept;
  logic       emit;

  assign in_ready = !rst && !flush
                 && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    win_d   = win_q;
    fill_d  = fill_q;
    state_d = state_q;
    emit    = 1'b0;
    if (accept) begin
      if (state_q == FILL && PAD_MODE) begin
        for (int i = 0; i < MEDIAN_N; i++)
          win_d[i] = in_data;
        state_d = RUN;
        emit    = 1'b1;
      end else begin
        for (int i = MEDIAN_N - 1; i > 0; i--)
          win_d[i] = win_q[i-1];
        win_d[0] = in_data;
        if (state_q == RUN) begin
          emit = 1'b1;
        end else if (fill_q == 3'(MEDIAN_N - 1)) begin
          state_d = RUN;
          fill_d  = 3'd0;
          emit    = 1'b1;
        end else begin
          fill_d = fill_q + 3'd1;
        end
      end
    end
  end

  median5_net u_net (
    .d0_i  (win_d[0]),
    .d1_i  (win_d[1]),
    .d2_i  (win_d[2]),
    .d3_i  (win_d[3]),
    .d4_i  (win_d[4]),
    .med_o (net_med)
  );

  // A fresh median always wins over draining the old one.
  assign ov_d  = emit | (ov_q & ~out_ready);
  assign med_d = emit ? net_med : med_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEDIAN_N; i++)
        win_q[i] <= '0;
      fill_q  <= 3'd0;
      state_q <= FILL;
      ov_q    <= 1'b0;
      med_q   <= '0;
    end else if (flush) begin
      for (int i = 0; i < MEDIAN_N; i++)
        win_q[i] <= '0;
      fill_q  <= 3'd0;
      state_q <= FILL;
      ov_q    <= 1'b0;
    end else begin
      win_q   <= win_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      ov_q    <= ov_d;
      med_q   <= med_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_median = med_q;

endmodule

// File: tb/tb_median_window_ctrl.sv
// Random and directed checks of both warm-up modes
// against a sorted-history reference model.
module tb_median_window_ctrl;
  import median_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  data_t       in_data = '0;
  logic        out_ready = 1'b1;
  logic [1:0]  rdy;
  logic [1:0]  ov;
  data_t       med [2];

  int checks = 0;
  int errors = 0;

  data_t hist [2][$];
  logic  mv   [2];
  data_t mmed [2];
  logic  rdy_e [2];

  always #5 clk = ~clk;

  median_window_ctrl #(.PAD_MODE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .out_valid(ov[0]),
    .out_ready(out_ready), .out_median(med[0])
  );

  median_window_ctrl #(.PAD_MODE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .out_valid(ov[1]),
    .out_ready(out_ready), .out_median(med[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic data_t ref_median(int m);
    data_t a [5];
    data_t t;
    for (int i = 0; i < 5; i++) a[i] = hist[m][i];
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 4 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[2];
  endfunction

  task automatic model_step(input int m, input logic v,
                            input data_t d, input logic ordy,
                            input logic fl, input logic r);
    if (r) begin
      hist[m].delete();
      mv[m]   = 1'b0;
      mmed[m] = '0;
    end else if (fl) begin
      hist[m].delete();
      mv[m] = 1'b0;
    end else if (v && rdy_e[m]) begin
      if (m == 1 && hist[m].size() == 0)
        repeat (5) hist[m].push_front(d);
      else
        hist[m].push_front(d);
      while (hist[m].size() > 5) void'(hist[m].pop_back());
      if (hist[m].size() == 5) begin
        mv[m]   = 1'b1;
        mmed[m] = ref_median(m);
      end else if (mv[m] && ordy) begin
        mv[m] = 1'b0;
      end
    end else if (mv[m] && ordy) begin
      mv[m] = 1'b0;
    end
  endtask

  task automatic cyc(input logic v, input data_t d,
                     input logic ordy, input logic fl,
                     input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    for (int m = 0; m < 2; m++) begin
      rdy_e[m] = !r && !fl && (!mv[m] || ordy);
      chk(m == 0 ? "in_ready0" : "in_ready1",
          32'(rdy[m]), 32'(rdy_e[m]));
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_step(m, v, d, ordy, fl, r);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk(m == 0 ? "out_valid0" : "out_valid1",
          32'(ov[m]), 32'(mv[m]));
      chk(m == 0 ? "out_median0" : "out_median1",
          med[m], mmed[m]);
    end
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  data_t seq1 [8] = '{10, 50, 30, 20, 40, 5, 60, 1};
  data_t exp1 [4] = '{30, 30, 30, 20};
  data_t pseq [4] = '{7, 100, 100, 100};
  data_t pexp [4] = '{7, 7, 7, 100};
  data_t useq [5] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF,
                      32'h0, 32'hFFFFFFFF};

  initial begin
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; mmed[m] = '0; rdy_e[m] = 1'b0;
    end
    @(negedge clk);
    do_reset();
    chk("reset_valid", 32'(ov[0]), 32'd0);
    chk("reset_median", med[0], 32'd0);

    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, seq1[i], 1'b1, 1'b0, 1'b0);
      if (i < 4) chk("fill_novalid", 32'(ov[0]), 32'd0);
      else chk("fill_median", med[0], exp1[i-4]);
    end

    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'd99, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd77, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'd3, 1'b1, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'(i + 40), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'd500, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'(i + 1), 1'b1, 1'b0, 1'b0);
      if (i < 4) chk("flush_novalid", 32'(ov[0]), 32'd0);
    end
    chk("flush_median", med[0], 32'd3);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, pseq[i], 1'b1, 1'b0, 1'b0);
      chk("pad_median", med[1], pexp[i]);
    end

    cyc(1'b1, 32'd8, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk("midrst_valid", 32'(ov[1]), 32'd0);
    chk("midrst_median", med[1], 32'd0);
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'(i * 3), 1'b1, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 5; i++)
      cyc(1'b1, useq[i], 1'b1, 1'b0, 1'b0);
    chk("unsigned_median", med[0], 32'hFFFFFFFF);

    for (int n = 0; n < 600; n++) begin
      logic  v, o, f, r;
      data_t d;
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 29) == 0);
      r = ($urandom_range(0, 79) == 0);
      d = ($urandom_range(0, 1) != 0) ? data_t'($urandom)
                                      : data_t'($urandom_range(0, 8));
      cyc(v, d, o, f, r);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/median_window_ctrl.md
# median_window_ctrl

Streaming sliding-window median controller. Accepts one 32-bit sample per handshake, keeps the five most recent samples in a shift window, and drives a shared combinational 5-input median network. It registers the network's median output behind a valid/ready interface. It sits between a sample source and downstream filtering logic, and it sequences warm-up, flush and backpressure for the median datapath.

## Interface
- PAD_MODE, default 0, selects warm-up behaviour.
  - 0: suppress output until 5 samples are held.
  - 1: replicate the first sample into all slots and emit from the first sample.
- clk  in  1  clock. Every register updates on the rising edge.
- rst  in  1  reset. Synchronous and active-high.
- flush  in  1  single-cycle pulse. Discards the window and any pending output.
- in_valid  in  1  source has a sample.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  32 (data_t)  sample, unsigned.
- out_valid  out  1  out_median is valid.
- out_ready  in  1  sink accepts the output.
- out_median  out  32 (data_t)  median of the 5-slot window after the accepting shift.

## Operation
- Accept = in_valid && in_ready.
- in_ready = !rst && !flush && (!out_valid || out_ready). This is combinational. There is a single output register and no skid buffer.
- Window w[0..4]: w[0] is the newest sample. On accept, w[i] ← w[i-1] and w[0] ← in_data.
- The median network is fed from the next-window value (the window after the shift), so the median is registered on the same edge as the accept.
- States:
  - FILL: fill_cnt is 0..4. This is the reset state.
  - RUN: the window is fully populated.
- PAD_MODE=0 in FILL:
  - An accept shifts the window and increments fill_cnt. It produces no output.
  - The accept with fill_cnt==4 goes to RUN and sets out_valid with the median of the 5 samples.
- PAD_MODE=1 in FILL:
  - The first accept loads in_data into all 5 slots and goes to RUN.
  - out_valid is set and out_median = in_data.
- RUN: every accept sets out_valid and loads out_median. This gives exactly one output per accepted sample.
- Output register:
  - out_valid clears on out_valid && out_ready && !accept.
  - On a simultaneous output handshake and accept, out_valid stays 1 and out_median takes the new value.
  - out_median is held stable while out_valid && !out_ready.
- Flush, on the next edge:
  - window ← 0, fill_cnt ← 0, state ← FILL, out_valid ← 0. Any pending output is dropped.
  - in_ready is 0 during the flush cycle, so a sample cannot be accepted alongside a flush.
- Comparisons are unsigned 32-bit (<=). Ties are stable, and any ordering among equal values yields the same median.

## Timing
- Reset values: out_valid 0, out_median 0, window all 0, fill_cnt 0, state FILL. in_ready is 0 while rst is high.
- Latency: a sample accepted at edge t produces out_valid=1 and the corresponding median in the cycle following edge t.
- Throughput: 1 sample/cycle when out_ready is held high.
- Reset mid-operation discards everything. Behaviour is identical to power-up reset.
- rst has priority over flush, and flush has priority over accept.
- fill_cnt saturates by leaving FILL and never wraps. In RUN, fill_cnt is don't-care and is held at 0.

## Structure
- Package median_pkg holds:
  - typedef data_t (logic [31:0]).
  - localparam MEDIAN_N = 5.
  - A state enum {FILL, RUN}.
- Sub-module median5_net: purely combinational.
  - Inputs: five data_t.
  - Output: median data_t.
  - It is a compare-exchange network of 7 comparators and 5 stages.
  - It is instantiated once and fed from the next-window value.
- The controller holds the window, fill_cnt, the FSM and the output register. Expected size is about 150–250 lines.

## Test plan
- **Fill and steady state (PAD_MODE=0), out_ready=1.** Feed 10, 50, 30, 20, 40, 5, 60, 1.
  - No out_valid for the first 4 samples.
  - Medians 30, 30, 30, 20 after samples 5–8, each one cycle after its accept.
- **Backpressure.** In RUN, hold out_ready=0 for 3 cycles with in_valid=1.
  - in_ready=0 for those cycles and out_median is stable.
  - On out_ready=1, the next sample is accepted in the same cycle.
- **Flush.** Flush after 3 accepted samples, then feed 1, 2, 3, 4, 5.
  - Only a single output, median 3, after the 5th sample.
  - The flush-cycle sample is refused (in_ready=0).
- **PAD_MODE=1.** Feed 7, then 100, 100, 100.
  - Outputs are 7, 7, 7, 100. The window after the 3rd sample is 100,100,7,7,7, so the median is 7.
- **Reset mid-RUN.** Assert rst with out_valid=1 pending.
  - Next cycle: out_valid=0 and out_median=0.
  - Subsequent outputs require 5 fresh samples.
- **Unsigned compare.** Feed 0xFFFFFFFF ×3 and 0x00000000 ×2, interleaved.
  - The median is 0xFFFFFFFF, not a signed interpretation.
